// File: rtl/phy_mem_ctrl.sv
// Physical memory controller: decodes MMU physical addresses onto a 1M x 32 SRAM
// or a memory-mapped UART (TX data register, RX byte FIFO, status register).
// Reads are combinational. Writes are latched and sequenced by a small FSM that
// holds mem_busy until the SRAM or UART transmitter has taken the data.
module phy_mem_ctrl #(
    parameter int unsigned WE_PULSE_CYCLES = 1,
    parameter int unsigned RX_FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    input  logic        mem_is_write,
    output logic        mem_busy,
    output logic [19:0] ram_addr,
    input  logic [31:0] ram_dq_i,
    output logic [31:0] ram_dq_o,
    output logic        ram_dq_oe,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_start,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid
);

    localparam int unsigned PtrW   = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned PulseW = (WE_PULSE_CYCLES > 1) ? $clog2(WE_PULSE_CYCLES) : 1;

    localparam logic [31:0] UartDataAddr = 32'h1FD0_03F8;
    localparam logic [31:0] UartStatAddr = 32'h1FD0_03FC;

    typedef enum logic [2:0] {
        StIdle,
        StSramSetup,
        StSramPulse,
        StSramHold,
        StTxWait
    } state_e;

    state_e              state;
    logic [19:0]         addr_lat;
    logic [31:0]         data_lat;
    logic [7:0]          tx_byte;
    logic [PulseW-1:0]   pulse_cnt;
    logic                we_n;
    logic                oe_n;
    logic                dq_oe;

    logic [7:0]          fifo_mem [RX_FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [CntW-1:0]     count;
    logic                ovr;

    logic sram_hit;
    logic data_hit;
    logic stat_hit;
    logic is_idle;
    logic fifo_empty;
    logic fifo_full;
    logic tx_rdy;
    logic stat_wr;
    logic pop_ok;
    logic push_ok;
    logic overrun;
    logic ovr_clr;

    // Address decode and derived status conditions
    always_comb begin
        sram_hit   = (mem_addr[31:22] == 10'd0);
        data_hit   = (mem_addr == UartDataAddr);
        stat_hit   = (mem_addr == UartStatAddr);
        is_idle    = (state == StIdle);
        fifo_empty = (count == '0);
        fifo_full  = (count == CntW'(RX_FIFO_DEPTH));
        tx_rdy     = !uart_tx_busy && is_idle;
        // Status writes are only honoured in IDLE; the MMU never writes while busy.
        stat_wr    = is_idle && mem_is_write && stat_hit;
        pop_ok     = stat_wr && mem_data_in[0] && !fifo_empty;
        ovr_clr    = stat_wr && mem_data_in[2];
        // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
        push_ok    = uart_rx_valid && (!fifo_full || pop_ok);
        overrun    = uart_rx_valid && fifo_full && !pop_ok;
    end

    // Combinational read data mux
    always_comb begin
        mem_data_out = '0;
        if (sram_hit) begin
            mem_data_out = ram_dq_i;
        end else if (data_hit) begin
            mem_data_out = fifo_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
        end else if (stat_hit) begin
            mem_data_out = {29'd0, ovr, !fifo_empty, tx_rdy};
        end
    end

    // Stall, SRAM pin and UART TX outputs
    always_comb begin
        mem_busy      = !is_idle || (mem_is_write && (sram_hit || data_hit));
        ram_addr      = is_idle ? mem_addr[21:2] : addr_lat;
        ram_dq_o      = data_lat;
        ram_dq_oe     = dq_oe;
        ram_ce_n      = 1'b0;
        ram_oe_n      = oe_n;
        ram_we_n      = we_n;
        uart_tx_data  = tx_byte;
        // Pulse lands in the last busy cycle so the MMU is released as the byte is taken.
        uart_tx_start = (state == StTxWait) && !uart_tx_busy;
    end

    // Write sequencing FSM with registered SRAM strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            addr_lat  <= '0;
            data_lat  <= '0;
            tx_byte   <= '0;
            pulse_cnt <= '0;
            we_n      <= 1'b1;
            oe_n      <= 1'b0;
            dq_oe     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (mem_is_write && sram_hit) begin
                        addr_lat <= mem_addr[21:2];
                        data_lat <= mem_data_in;
                        dq_oe    <= 1'b1;
                        oe_n     <= 1'b1;
                        we_n     <= 1'b1;
                        state    <= StSramSetup;
                    end else if (mem_is_write && data_hit) begin
                        tx_byte <= mem_data_in[7:0];
                        state   <= StTxWait;
                    end
                end
                StSramSetup: begin
                    we_n      <= 1'b0;
                    pulse_cnt <= PulseW'(WE_PULSE_CYCLES - 1);
                    state     <= StSramPulse;
                end
                StSramPulse: begin
                    if (pulse_cnt == '0) begin
                        we_n  <= 1'b1;
                        state <= StSramHold;
                    end else begin
                        pulse_cnt <= pulse_cnt - PulseW'(1);
                    end
                end
                StSramHold: begin
                    // Data stays driven through hold; release the bus on the way out.
                    dq_oe <= 1'b0;
                    oe_n  <= 1'b0;
                    state <= StIdle;
                end
                StTxWait: begin
                    if (!uart_tx_busy) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // RX FIFO pointers, occupancy and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count + CntW'(push_ok) - CntW'(pop_ok);
            // A fresh overrun wins over a same-cycle clear so the event is not lost.
            if (overrun) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    // RX FIFO storage (no reset needed; occupancy gates every read)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= uart_rx_data;
        end
    end

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Scoreboard bench for phy_mem_ctrl: stimulus pushes expected reads, SRAM writes
// and TX bytes into queues; a negedge monitor pops and compares when the DUT
// presents the matching event.
module tb_phy_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_is_write;
    logic        mem_busy;
    logic [19:0] ram_addr;
    logic [31:0] ram_dq_i;
    logic [31:0] ram_dq_o;
    logic        ram_dq_oe;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic        uart_tx_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;

    localparam logic [31:0] DataA = 32'h1FD0_03F8;
    localparam logic [31:0] StatA = 32'h1FD0_03FC;

    phy_mem_ctrl #(
        .WE_PULSE_CYCLES(1),
        .RX_FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_is_write (mem_is_write),
        .mem_busy     (mem_busy),
        .ram_addr     (ram_addr),
        .ram_dq_i     (ram_dq_i),
        .ram_dq_o     (ram_dq_o),
        .ram_dq_oe    (ram_dq_oe),
        .ram_ce_n     (ram_ce_n),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n),
        .uart_tx_data (uart_tx_data),
        .uart_tx_start(uart_tx_start),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        rd_req   = 1'b0;
    logic [31:0] exp_rd[$];
    logic [51:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [51:0] wr_e;
    logic [31:0] rd_e;
    logic [7:0]  tx_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event with no expected entry queued", name);
    endtask

    // Monitor: compares DUT events against the scoreboard queues
    always @(negedge clk) begin
        if (rd_req) begin
            if (exp_rd.size() == 0) unexpected("rd_unexpected");
            else begin
                rd_e = exp_rd.pop_front();
                check("rd_data", mem_data_out, rd_e);
            end
        end
        if (!rst && !ram_we_n) begin
            if (exp_wr.size() == 0) unexpected("sram_wr_unexpected");
            else begin
                wr_e = exp_wr.pop_front();
                check("sram_wr_addr", {12'd0, ram_addr}, {12'd0, wr_e[51:32]});
                check("sram_wr_data", ram_dq_o, wr_e[31:0]);
                check("sram_wr_oe", {31'd0, ram_dq_oe}, 32'd1);
            end
        end
        if (uart_tx_start) begin
            if (exp_tx.size() == 0) unexpected("tx_unexpected");
            else begin
                tx_e = exp_tx.pop_front();
                check("tx_data", {24'd0, uart_tx_data}, {24'd0, tx_e});
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] e);
        @(posedge clk); #1;
        mem_addr     = a;
        mem_is_write = 1'b0;
        exp_rd.push_back(e);
        rd_req = 1'b1;
        @(negedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic stat_write(input logic [31:0] d);
        @(posedge clk); #1;
        mem_addr     = StatA;
        mem_data_in  = d;
        mem_is_write = 1'b1;
        #1 check("stat_wr_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        mem_is_write = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(posedge clk); #1;
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int busy_cycles;
    int we_low;
    int start_cnt;
    int start_at;
    logic dq_bad;
    logic addr_bad;

    initial begin
        rst           = 1'b1;
        mem_addr      = '0;
        mem_data_in   = '0;
        mem_is_write  = 1'b0;
        ram_dq_i      = '0;
        uart_tx_busy  = 1'b0;
        uart_rx_data  = '0;
        uart_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: {we_n, dq_oe, oe_n, ce_n, tx_start, busy}
        check("reset_strobes",
              {26'd0, ram_we_n, ram_dq_oe, ram_oe_n, ram_ce_n, uart_tx_start, mem_busy},
              32'b10_0000);
        check("reset_dq_o", ram_dq_o, 32'd0);

        // SRAM read
        ram_dq_i = 32'hDEAD_BEEF;
        do_read(32'h0000_0010, 32'hDEAD_BEEF);
        check("rd_ram_addr", {12'd0, ram_addr}, 32'd4);
        check("rd_busy", {31'd0, mem_busy}, 32'd0);

        // Unmapped reads return zero
        do_read(32'h0040_0000, 32'd0);
        do_read(32'h1FD0_0400, 32'd0);

        // SRAM write: 4 busy cycles, single we_n low cycle, latched address/data
        @(posedge clk); #1;
        mem_addr     = 32'h0000_0100;
        mem_data_in  = 32'h1234_5678;
        mem_is_write = 1'b1;
        exp_wr.push_back({20'h00040, 32'h1234_5678});
        busy_cycles = 0;
        we_low      = 0;
        dq_bad      = 1'b0;
        addr_bad    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_busy) busy_cycles++;
            if (!ram_we_n) we_low++;
            if (ram_dq_oe && ram_dq_o !== 32'h1234_5678) dq_bad = 1'b1;
            if (mem_busy && ram_addr !== 20'h00040) addr_bad = 1'b1;
            @(posedge clk); #1;
            mem_is_write = 1'b0;
            mem_addr     = 32'h0000_0FF0;
            mem_data_in  = 32'hFFFF_0000;
        end
        check("sram_busy_cycles", busy_cycles, 32'd4);
        check("sram_we_low_cycles", we_low, 32'd1);
        check("sram_dq_stable", {31'd0, dq_bad}, 32'd0);
        check("sram_addr_held", {31'd0, addr_bad}, 32'd0);
        check("sram_dq_released", {31'd0, ram_dq_oe}, 32'd0);

        // Unmapped write: no busy, no SRAM strobe
        @(posedge clk); #1;
        mem_addr     = 32'h0040_0000;
        mem_is_write = 1'b1;
        #1 check("unmapped_wr_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        mem_is_write = 1'b0;

        // UART TX with transmitter busy for 5 cycles
        uart_tx_busy = 1'b1;
        @(posedge clk); #1;
        mem_addr     = DataA;
        mem_data_in  = 32'h0000_0041;
        mem_is_write = 1'b1;
        exp_tx.push_back(8'h41);
        busy_cycles = 0;
        start_cnt   = 0;
        start_at    = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_busy) busy_cycles++;
            if (uart_tx_start) begin
                start_cnt++;
                start_at = i;
            end
            @(posedge clk); #1;
            mem_is_write = 1'b0;
            if (i == 5) uart_tx_busy = 1'b0;
        end
        check("tx_busy_cycles", busy_cycles, 32'd7);
        check("tx_start_count", start_cnt, 32'd1);
        check("tx_start_cycle", start_at, 32'd6);
        do_read(StatA, 32'b001);

        // RX FIFO overrun: five pushes into a 4-deep FIFO
        uart_tx_busy = 1'b1;
        push_rx(8'h11);
        push_rx(8'h22);
        push_rx(8'h33);
        push_rx(8'h44);
        push_rx(8'h55);
        do_read(StatA, 32'b110);
        do_read(DataA, 32'h11);
        stat_write(32'h1);
        do_read(DataA, 32'h22);
        stat_write(32'h1);
        do_read(DataA, 32'h33);
        stat_write(32'h1);
        do_read(DataA, 32'h44);
        stat_write(32'h1);
        do_read(StatA, 32'b100);
        do_read(DataA, 32'h0);
        stat_write(32'h1);              // pop on empty is ignored
        stat_write(32'h4);              // clear overrun
        do_read(StatA, 32'b000);

        // Full FIFO with push and pop in the same cycle
        push_rx(8'hA1);
        push_rx(8'hA2);
        push_rx(8'hA3);
        push_rx(8'hA4);
        @(posedge clk); #1;
        uart_rx_data  = 8'hA5;
        uart_rx_valid = 1'b1;
        mem_addr      = StatA;
        mem_data_in   = 32'h1;
        mem_is_write  = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        mem_is_write  = 1'b0;
        do_read(StatA, 32'b010);
        do_read(DataA, 32'hA2);
        stat_write(32'h1);
        do_read(DataA, 32'hA3);
        stat_write(32'h1);
        do_read(DataA, 32'hA4);
        stat_write(32'h1);
        do_read(DataA, 32'hA5);
        stat_write(32'h1);
        do_read(StatA, 32'b000);

        // Empty FIFO with push and pop in the same cycle: push wins
        @(posedge clk); #1;
        uart_rx_data  = 8'hB1;
        uart_rx_valid = 1'b1;
        mem_addr      = StatA;
        mem_data_in   = 32'h1;
        mem_is_write  = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        mem_is_write  = 1'b0;
        do_read(DataA, 32'hB1);
        do_read(StatA, 32'b010);

        // Asynchronous reset during the write pulse
        uart_tx_busy = 1'b0;
        @(posedge clk); #1;
        mem_addr     = 32'h0000_0200;
        mem_data_in  = 32'hCAFE_F00D;
        mem_is_write = 1'b1;
        @(posedge clk); #1;
        mem_is_write = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_we_n", {31'd0, ram_we_n}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_we_n", {31'd0, ram_we_n}, 32'd1);
        check("rst_async_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
        check("rst_async_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_read(StatA, 32'b001);

        repeat (3) @(posedge clk);
        check("rd_queue_drained", exp_rd.size(), 32'd0);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("tx_queue_drained", exp_tx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
